// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU data-port and TX drain bus for data_mem_responder
//
// Purpose: groups the CPU data-memory handshake (addressM/outM/writeM/inM)
// and the TX FIFO drain stream (tx_data/tx_valid/tx_ready) into one bundle.
// Modports:
//   master : CPU / TX consumer side (drives address, write data, strobe, tx_ready)
//   slave  : data_mem_responder side (drives inM, tx_data, tx_valid)
interface data_mem_responder_if #(
    parameter int WordSize    = 16,
    parameter int MemAddrSize = 15
);
    logic [MemAddrSize-1:0] addressM;
    logic [WordSize-1:0]    outM;
    logic                   writeM;
    logic [WordSize-1:0]    inM;
    logic [WordSize-1:0]    tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (
        output addressM, outM, writeM, tx_ready,
        input  inM, tx_data, tx_valid
    );

    modport slave (
        input  addressM, outM, writeM, tx_ready,
        output inM, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM plus KBD/TXD/STAT memory-mapped I/O responder
//
// Purpose: answers the CPU data port with a combinational inM, backs a
// RamWords-deep RAM at 0..RamWords-1 and maps I/O registers:
//   0x6000 KBD  (read-only, 2-flop synchronized kbd_data)
//   0x6001 TXD  (write-only, pushes into the TX FIFO; reads 0)
//   0x6002 STAT (full, empty, ovf, bad, occupancy count; any write clears ovf/bad)
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   kbd_data : asynchronous keyboard code, 0 = no key
//   bus      : data_mem_responder_if.slave (CPU data port + TX drain stream)
// Configuration macro: DATA_MEM_RESPONDER_BAD_ACCESS_EN
//   defined   -> writes to unmapped addresses or KBD set sticky STAT bit3 (bad)
//   undefined -> STAT bit3 reads 0 and no flag register exists
module data_mem_responder #(
    parameter int WordSize    = 16,
    parameter int MemAddrSize = 15,
    parameter int RamWords    = 16384,
    parameter int FifoDepth   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WordSize-1:0] kbd_data,
    data_mem_responder_if.slave bus
);
    localparam int AW    = $clog2(FifoDepth);
    localparam int PW    = AW + 1;
    localparam int RamAw = $clog2(RamWords);

    localparam logic [MemAddrSize-1:0] KbdAddr  = MemAddrSize'(16'h6000);
    localparam logic [MemAddrSize-1:0] TxdAddr  = MemAddrSize'(16'h6001);
    localparam logic [MemAddrSize-1:0] StatAddr = MemAddrSize'(16'h6002);

    // ---------------- address decode ----------------
    logic             ram_sel, kbd_sel, txd_sel, stat_sel;
    logic [RamAw-1:0] ram_idx;

    assign ram_sel  = int'(bus.addressM) < RamWords;
    assign kbd_sel  = bus.addressM == KbdAddr;
    assign txd_sel  = bus.addressM == TxdAddr;
    assign stat_sel = bus.addressM == StatAddr;
    assign ram_idx  = bus.addressM[RamAw-1:0];

    // ---------------- RAM (not reset, survives reset) ----------------
    logic [WordSize-1:0] ram_mem [RamWords];

    always_ff @(posedge clk) begin
        if (bus.writeM && ram_sel) begin
            ram_mem[ram_idx] <= bus.outM;
        end
    end

    // ---------------- KBD synchronizer ----------------
    logic [WordSize-1:0] kbd_s1_q, kbd_s2_q;

    // ---------------- TX FIFO ----------------
    logic [WordSize-1:0] fifo_mem [FifoDepth];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       count;
    logic                full, empty, push_req, push_ok, pop;
    logic                stat_wr;
    logic                ovf_q, ovf_d, ovf_set;
    logic                bad_flag;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign pop      = !empty && bus.tx_ready;
    assign push_req = bus.writeM && txd_sel;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign stat_wr  = bus.writeM && stat_sel;

    assign bus.tx_valid = !empty;
    // Head is masked while empty so stale storage never shows on tx_data.
    assign bus.tx_data  = empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= bus.outM;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A set in the same cycle as a clear takes priority.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (stat_wr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            kbd_s1_q <= '0;
            kbd_s2_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            kbd_s1_q <= kbd_data;
            kbd_s2_q <= kbd_s1_q;
        end
    end

    // ---------------- optional bad-access flag ----------------
`ifdef DATA_MEM_RESPONDER_BAD_ACCESS_EN
    logic bad_q, bad_d, bad_set, unmapped;

    assign unmapped = !ram_sel && !kbd_sel && !txd_sel && !stat_sel;
    assign bad_set  = bus.writeM && (unmapped || kbd_sel);

    always_comb begin
        bad_d = bad_q;
        if (bad_set) begin
            bad_d = 1'b1;
        end else if (stat_wr) begin
            bad_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign bad_flag = bad_q;
`else
    assign bad_flag = 1'b0;
`endif

    // ---------------- STAT and read mux ----------------
    logic [WordSize-1:0] stat;

    always_comb begin
        stat         = '0;
        stat[0]      = full;
        stat[1]      = empty;
        stat[2]      = ovf_q;
        stat[3]      = bad_flag;
        stat[4 +: PW] = count;
    end

    always_comb begin
        bus.inM = '0;
        if (ram_sel) begin
            bus.inM = ram_mem[ram_idx];
        end else if (kbd_sel) begin
            bus.inM = kbd_s2_q;
        end else if (stat_sel) begin
            bus.inM = stat;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam int FD = 4;
    localparam logic [14:0] KBD  = 15'h6000;
    localparam logic [14:0] TXD  = 15'h6001;
    localparam logic [14:0] STAT = 15'h6002;
`ifdef DATA_MEM_RESPONDER_BAD_ACCESS_EN
    localparam logic [15:0] BAD_BIT = 16'h0008;
`else
    localparam logic [15:0] BAD_BIT = 16'h0000;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] kbd_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    data_mem_responder_if #(.WordSize(16), .MemAddrSize(15)) dif ();

    data_mem_responder #(
        .WordSize(16), .MemAddrSize(15), .RamWords(16384), .FifoDepth(FD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .kbd_data (kbd_data),
        .bus      (dif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pops happen at the next rising edge; inputs are stable from here until then.
    always @(negedge clk) begin
        if (reset && dif.tx_valid && dif.tx_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                check_eq("tx_data", dif.tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [14:0] a, input logic [15:0] d);
        dif.addressM = a;
        dif.outM     = d;
        dif.writeM   = 1'b1;
        if (a == TXD && (exp_q.size() < FD || dif.tx_ready)) begin
            exp_q.push_back(d);
        end
        step();
        dif.writeM = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [14:0] a, input logic [15:0] exp);
        dif.addressM = a;
        dif.writeM   = 1'b0;
        #1;
        check_eq(tag, dif.inM, exp);
    endtask

    task automatic drain(input string tag);
        dif.tx_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            step();
        end
        check_eq(tag, exp_q.size(), 0);
        dif.tx_ready = 1'b0;
        #1;
        check_eq("drain_valid_low", dif.tx_valid, 0);
    endtask

    initial begin
        reset        = 1'b0;
        kbd_data     = 16'h0;
        dif.addressM = '0;
        dif.outM     = '0;
        dif.writeM   = 1'b0;
        dif.tx_ready = 1'b0;
        step();
        check_eq("rst_tx_valid", dif.tx_valid, 0);
        step();
        reset = 1'b1;
        rd_check("rst_stat", STAT, 16'h0002);
        rd_check("rst_kbd", KBD, 16'h0000);
        check_eq("rst_tx_data", dif.tx_data, 0);

        // RAM: same-cycle read returns old word, next cycle the new one
        bus_write(15'd5, 16'h0BAD);
        dif.addressM = 15'd5;
        dif.outM     = 16'h1234;
        dif.writeM   = 1'b1;
        #1;
        check_eq("ram_old_word", dif.inM, 16'h0BAD);
        step();
        dif.writeM = 1'b0;
        rd_check("ram_new_word", 15'd5, 16'h1234);
        bus_write(15'h3FFF, 16'hBEEF);
        rd_check("ram_top", 15'h3FFF, 16'hBEEF);

        // KBD synchronizer latency
        kbd_data = 16'h0041;
        rd_check("kbd_0edge", KBD, 16'h0000);
        step();
        rd_check("kbd_1edge", KBD, 16'h0000);
        step();
        rd_check("kbd_2edge", KBD, 16'h0041);

        // FIFO fill to overflow, then drain
        for (int i = 1; i <= 5; i++) begin
            bus_write(TXD, 16'(i));
            if (i == 1) check_eq("tx_valid_push", dif.tx_valid, 1);
        end
        rd_check("stat_full_ovf", STAT, 16'h0045);
        drain("drain1_timeout");
        rd_check("stat_after_drain", STAT, 16'h0006);
        bus_write(STAT, 16'hFFFF);
        rd_check("stat_cleared", STAT, 16'h0002);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) bus_write(TXD, 16'(i));
        dif.tx_ready = 1'b1;
        bus_write(TXD, 16'd9);
        dif.tx_ready = 1'b0;
        rd_check("stat_full_pushpop", STAT, 16'h0041);
        drain("drain2_timeout");
        rd_check("stat_empty2", STAT, 16'h0002);

        // Out-of-RAM addresses read 0 and do not alias
        bus_write(15'd0, 16'h1111);
        bus_write(15'h4000, 16'h2222);
        rd_check("unmapped_read", 15'h4000, 16'h0000);
        rd_check("ram0_no_alias", 15'd0, 16'h1111);
        rd_check("txd_reads0", TXD, 16'h0000);
        bus_write(STAT, 16'h0000);

        // Bad-access flag
        bus_write(15'h7000, 16'h5555);
        rd_check("stat_bad_7000", STAT, 16'h0002 | BAD_BIT);
        bus_write(STAT, 16'h0000);
        rd_check("stat_bad_clear", STAT, 16'h0002);
        bus_write(KBD, 16'h5555);
        rd_check("stat_bad_kbd", STAT, 16'h0002 | BAD_BIT);
        bus_write(STAT, 16'h0000);

        // Reset asserted mid-drain
        bus_write(TXD, 16'h0007);
        bus_write(TXD, 16'h0008);
        dif.tx_ready = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        dif.tx_ready = 1'b0;
        #1;
        check_eq("rst_mid_valid", dif.tx_valid, 0);
        check_eq("rst_mid_data", dif.tx_data, 0);
        step();
        reset = 1'b1;
        rd_check("ram_kept", 15'd5, 16'h1234);
        rd_check("stat_after_rst", STAT, 16'h0002);
        rd_check("kbd_after_rst", KBD, 16'h0000);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
